// File: rtl/uart_dram_loader_if.sv
// DRAM write-port bundle driven by the UART loader.
// The loader is the master; the DRAM write mux is the slave.
interface uart_dram_loader_if;
    logic [15:0] DRAM_address_receiver;
    logic [7:0]  DRAM_data_receiver;
    logic        write_DRAM_receiver;

    modport master (
        output DRAM_address_receiver,
        output DRAM_data_receiver,
        output write_DRAM_receiver
    );

    modport slave (
        input DRAM_address_receiver,
        input DRAM_data_receiver,
        input write_DRAM_receiver
    );
endinterface

// File: rtl/uart_dram_loader.sv
// 8N1 UART receiver that writes LOAD_BYTES bytes to sequential DRAM addresses from 0,
// then raises Rx_done so the processor takes over the DRAM port.
module uart_dram_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int LOAD_BYTES   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Rx,
    uart_dram_loader_if.master  dram,
    output logic                Rx_done,
    output logic                frame_error
);

    localparam logic [15:0] CPB_M1   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
    localparam logic [16:0] LOAD_CNT = 17'(LOAD_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_sync_q;
    logic        rx_s;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] addr_q, addr_d;
    logic [16:0] byte_cnt_q, byte_cnt_d;
    logic        wr_q, wr_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        mid_hit_s;
    logic        bit_hit_s;
    logic        last_byte_s;

    assign rx_s        = rx_sync_q;
    assign mid_hit_s   = (clk_cnt_q == HALF_CNT);
    assign bit_hit_s   = (clk_cnt_q == CPB_M1);
    assign last_byte_s = ((byte_cnt_q + 17'd1) == LOAD_CNT);

    // Two-flop synchronizer; presets high so a reset looks like an idle line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (mid_hit_s) begin
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_hit_s && (bit_idx_q == 3'd7)) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (bit_hit_s) begin
                    state_d = rx_s ? S_WRITE : S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WRITE: begin
                if (last_byte_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output next values; the write strobe is registered from state_d.
    always_comb begin
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        ferr_d     = ferr_q;
        wr_d       = (state_d == S_WRITE);
        done_d     = done_q | (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = 16'd0;
                bit_idx_d = 3'd0;
            end
            S_START: begin
                if (mid_hit_s) begin
                    clk_cnt_d = 16'd0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_hit_s) begin
                    clk_cnt_d = 16'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_hit_s) begin
                    clk_cnt_d = 16'd0;
                    if (rx_s) begin
                        data_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_WRITE: begin
                byte_cnt_d = byte_cnt_q + 17'd1;
                // The final address is held so it never wraps back to 0.
                if (last_byte_s) begin
                    addr_d = addr_q;
                end else begin
                    addr_d = addr_q + 16'd1;
                end
            end
            S_DONE: begin
                clk_cnt_d = 16'd0;
            end
            default: begin
                clk_cnt_d = 16'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt_q  <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            addr_q     <= 16'd0;
            byte_cnt_q <= 17'd0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign dram.DRAM_address_receiver = addr_q;
    assign dram.DRAM_data_receiver    = data_q;
    assign dram.write_DRAM_receiver   = wr_q;
    assign Rx_done                    = done_q;
    assign frame_error                = ferr_q;

endmodule

// File: doc/uart_dram_loader.md
Name: uart_dram_loader

Overview:
- UART receiver and DRAM loader that fills data memory before the processor runs.
- Receives 8N1 serial bytes on Rx and writes each byte to sequential DRAM addresses starting at 0.
- After LOAD_BYTES bytes, asserts Rx_done. Rx_done releases the processor enable and switches the DRAM write-data, write-enable and address muxes over to the processor.
- Sits directly upstream of the DRAM write port and the processor enable.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
- LOAD_BYTES, 1024, number of bytes to load before Rx_done; legal range 1..65536.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Rx  input  1  UART serial line; idles high; asynchronous to clk.
- DRAM_address_receiver  output  16  DRAM address for the current write.
- DRAM_data_receiver  output  8  received byte for DRAM.
- write_DRAM_receiver  output  1  one-cycle DRAM write-enable pulse.
- Rx_done  output  1  load complete; held high until reset.
- frame_error  output  1  sticky flag; set on any bad stop bit.

Behaviour:
- Reset values (asynchronous, immediate on reset=1):
  - DRAM_address_receiver=0, DRAM_data_receiver=0, write_DRAM_receiver=0, Rx_done=0, frame_error=0.
  - FSM in IDLE; bit counter and clock counter at 0; byte count at 0.
  - Synchronizer flops preset to 1.
- Rx passes through a 2-flop synchronizer (rx_s). All sampling below uses rx_s, never raw Rx.
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP, WRITE, DONE.
- IDLE:
  - Clock counter held at 0.
  - rx_s==0 -> START.
- START:
  - Counts to CLKS_PER_BIT/2 (integer division), i.e. the mid start bit.
  - If rx_s==0 there: counter cleared, go to DATA.
  - If rx_s==1 (glitch / false start): go to IDLE with no write.
- DATA:
  - Samples rx_s every CLKS_PER_BIT cycles.
  - 8 bits, LSB first, shifted into the data register.
  - After bit 7 -> STOP.
- STOP:
  - Samples rx_s after CLKS_PER_BIT cycles (mid stop bit).
  - rx_s==1: load DRAM_data_receiver with the shift register, go to WRITE.
  - rx_s==0: set frame_error, discard the byte (no write, address unchanged), go to IDLE.
  - After a framing error, IDLE may re-trigger immediately on a low line; this is the required behaviour.
- WRITE:
  - Exactly one cycle with write_DRAM_receiver=1.
  - DRAM_address_receiver and DRAM_data_receiver are stable for that cycle.
  - On the next edge:
    - write_DRAM_receiver -> 0.
    - Byte count increments.
    - If the byte count reached LOAD_BYTES: go to DONE. Address is not incremented (it holds the last written address).
    - Otherwise: address increments by 1 (16-bit) and the FSM goes to IDLE.
- Latency: write pulse is high on the cycle after the mid-stop-bit sample.
- DONE:
  - Rx_done=1 on entry and held.
  - Rx is ignored entirely.
  - No further writes.
  - frame_error frozen.
  - Exit only via reset.
- Address wrap: with LOAD_BYTES=65536, the last write is to 0xFFFF and DONE is entered. The address never wraps to 0 while loading.
- Byte counter is 17 bits wide so that LOAD_BYTES=65536 is representable.
- frame_error:
  - Cleared only by reset.
  - Does not stop loading; good bytes continue at the next address.
- Reset mid-frame or mid-WRITE:
  - Write pulse drops immediately.
  - Partial byte is lost.
  - Next load restarts at address 0.
- Reset released while Rx is low (mid-frame): the synchronizer emerges high, then sees low. START is entered; a false start is rejected only if rx_s is high at the mid-bit sample. The bench must idle Rx high after reset for a clean start.

Test Plan:
- Reset check: assert reset, drive Rx=1 -> all outputs 0. Release reset, idle for 5 bit times -> no write pulse, Rx_done=0.
- Single byte: CLKS_PER_BIT=16, send 0xA5 -> exactly one 1-cycle write_DRAM_receiver pulse with address 0x0000 and data 0xA5. Pulse occurs 1 cycle after the mid-stop sample; frame_error=0.
- Full load: LOAD_BYTES=4, send 0x11,0x22,0x33,0x44 -> writes to addresses 0..3 with matching data. Rx_done rises on the cycle after the 4th write pulse. A 5th byte 0x55 -> no write, Rx_done stays 1.
- False start and framing error:
  - Rx low for 4 cycles (less than CLKS_PER_BIT/2=8) -> no write.
  - Send 0x3C with stop bit=0 -> no write, frame_error=1.
  - Then send 0x7E -> written at address 0, frame_error stays 1.
- Reset mid-operation: LOAD_BYTES=4, send 2 bytes, assert reset during data bit 3 of the 3rd byte -> outputs cleared at once. Release, send 4 bytes -> writes start at address 0; Rx_done after the 4th.
